// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants, mode/state enums and mode decode for aes_mode_ctrl.
// Optional feature macro: AES_MODE_CTR_EN (counter mode decode).
package aes_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        ECB  = 2'b00,
        CBC  = 2'b01,
        CTR  = 2'b10,
        RSVD = 2'b11
    } aes_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        WAIT  = 2'b10,
        OUT   = 2'b11
    } aes_ctrl_state_t;

    // Collapse the mode field to the modes this build implements; everything else runs as ECB.
    function automatic aes_mode_t eff_mode(input logic [1:0] mode);
`ifdef AES_MODE_CTR_EN
        eff_mode = (mode == 2'b01) ? CBC : ((mode == 2'b10) ? CTR : ECB);
`else
        eff_mode = (mode == 2'b01) ? CBC : ECB;
`endif
    endfunction

endpackage

// File: rtl/aes_chain_bank.sv
// rtl/aes_chain_bank.sv - per-channel chain registers with IV load and busy-channel drop.
module aes_chain_bank
    import aes_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 HCLK,
    input  logic                 rst,
    input  logic                 i_iv_load,
    input  logic [CH_W-1:0]      i_iv_ch,
    input  logic [AES_BLK_W-1:0] i_iv_data,
    input  logic                 i_busy,
    input  logic [CH_W-1:0]      i_act_ch,
    input  logic                 i_upd_en,
    input  logic [AES_BLK_W-1:0] i_upd_data,
    output logic [AES_BLK_W-1:0] o_rd_data,
    output logic                 o_iv_drop
);

    logic [AES_BLK_W-1:0] r_chain [NUM_CH];
    logic                 r_drop;
    logic                 w_hit;

    // The active channel's chain must not move under an in-flight block.
    assign w_hit     = i_iv_load && i_busy && (i_iv_ch == i_act_ch);
    assign o_iv_drop = r_drop;

    always_ff @(posedge HCLK) begin
        if (rst) begin
            r_drop <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) r_chain[i] <= '0;
        end else begin
            r_drop <= w_hit;
            for (int i = 0; i < NUM_CH; i++) begin
                if (i_upd_en && (i_act_ch == CH_W'(i)))
                    r_chain[i] <= i_upd_data;
                else if (i_iv_load && !w_hit && (i_iv_ch == CH_W'(i)))
                    r_chain[i] <= i_iv_data;
            end
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (i_act_ch == CH_W'(i)) o_rd_data = r_chain[i];
    end

endmodule

// File: rtl/aes_mode_ctrl.sv
// rtl/aes_mode_ctrl.sv - ECB/CBC/CTR chaining controller around a single-block cipher core.
// Optional feature macro: AES_MODE_CTR_EN (counter mode; mode 10 runs as ECB without it).
module aes_mode_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 HCLK,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_data,
    input  logic [CH_W-1:0]      in_ch,
    input  logic                 in_encrypt,
    input  logic [1:0]           in_mode,
    input  logic                 iv_load,
    input  logic [CH_W-1:0]      iv_ch,
    input  logic [AES_BLK_W-1:0] iv_data,
    output logic                 iv_drop,
    output logic                 core_start,
    output logic                 core_encrypt,
    output logic [AES_BLK_W-1:0] core_data,
    input  logic                 core_done,
    input  logic [AES_BLK_W-1:0] core_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_data,
    output logic [CH_W-1:0]      out_ch,
    output logic                 busy
);

    aes_ctrl_state_t      r_state, w_next;
    logic [AES_BLK_W-1:0] r_data, r_out_data;
    logic [CH_W-1:0]      r_ch, r_out_ch;
    logic                 r_enc, r_rdy;
    aes_mode_t            r_mode;

    logic                 w_accept, w_done, w_upd_en, w_core_enc;
    logic [AES_BLK_W-1:0] w_chain, w_core_data, w_out_nxt, w_upd_data;

    assign w_accept = in_valid && in_ready;
    assign w_done   = (r_state == WAIT) && core_done;

    always_ff @(posedge HCLK) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_accept)  w_next = START;
            START:                w_next = WAIT;
            WAIT:  if (core_done) w_next = OUT;
            OUT:   if (out_ready) w_next = IDLE;
            default:              w_next = IDLE;
        endcase
    end

    // r_rdy holds in_ready low until the first edge after reset is released.
    always_comb begin
        in_ready   = (r_state == IDLE) && r_rdy;
        core_start = (r_state == START);
        out_valid  = (r_state == OUT);
        busy       = (r_state != IDLE);
    end

    always_ff @(posedge HCLK) begin
        if (rst) begin
            r_rdy      <= 1'b0;
            r_data     <= '0;
            r_ch       <= '0;
            r_enc      <= 1'b0;
            r_mode     <= ECB;
            r_out_data <= '0;
            r_out_ch   <= '0;
        end else begin
            r_rdy <= 1'b1;
            if (w_accept) begin
                r_data <= in_data;
                r_ch   <= in_ch;
                r_enc  <= in_encrypt;
                r_mode <= eff_mode(in_mode);
            end
            if (w_done) begin
                r_out_data <= w_out_nxt;
                r_out_ch   <= r_ch;
            end
        end
    end

    // Chain of the captured channel cannot change while busy, so the core input stays put.
    always_comb begin
        w_core_data = r_data;
        w_core_enc  = r_enc;
        w_out_nxt   = core_result;
        w_upd_en    = 1'b0;
        w_upd_data  = core_result;
        case (r_mode)
            CBC: begin
                w_upd_en = w_done;
                if (r_enc) begin
                    w_core_data = r_data ^ w_chain;
                end else begin
                    w_out_nxt  = core_result ^ w_chain;
                    w_upd_data = r_data;
                end
            end
`ifdef AES_MODE_CTR_EN
            CTR: begin
                w_core_data = w_chain;
                w_core_enc  = 1'b1;
                w_out_nxt   = r_data ^ core_result;
                w_upd_en    = w_done;
                w_upd_data  = {w_chain[AES_BLK_W-1:32], w_chain[31:0] + 32'd1};
            end
`endif
            default: ;
        endcase
    end

    assign core_data    = w_core_data;
    assign core_encrypt = w_core_enc;
    assign out_data     = r_out_data;
    assign out_ch       = r_out_ch;

    aes_chain_bank #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_chain_bank (
        .HCLK       (HCLK),
        .rst        (rst),
        .i_iv_load  (iv_load),
        .i_iv_ch    (iv_ch),
        .i_iv_data  (iv_data),
        .i_busy     (busy),
        .i_act_ch   (r_ch),
        .i_upd_en   (w_upd_en),
        .i_upd_data (w_upd_data),
        .o_rd_data  (w_chain),
        .o_iv_drop  (iv_drop)
    );

endmodule

// File: doc/aes_mode_ctrl.md
AES_MODE_CTRL -- requirements
Module: aes_mode_ctrl

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-high; the ports SHALL be named HCLK and rst.
REQ-002 Parameter NUM_CH SHALL default to 4 and set the number of independent chaining channels (1..16).
REQ-003 Parameter CH_W SHALL default to max(1,$clog2(NUM_CH)) and set the channel-index width.
REQ-004 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- HCLK  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  block offered.
- in_ready  out  1  block accepted when high together with in_valid.
- in_data  in  128  plaintext or ciphertext.
- in_ch  in  CH_W  channel.
- in_encrypt  in  1  1 = encrypt, 0 = decrypt.
- in_mode  in  2  00 = ECB, 01 = CBC, 10 = CTR, 11 = reserved.
- iv_load  in  1  load the chain register.
- iv_ch  in  CH_W  channel to load.
- iv_data  in  128  IV or initial counter.
- iv_drop  out  1  one-cycle pulse: the IV load was rejected.
- core_start  out  1  one-cycle request to the cipher core.
- core_encrypt  out  1  direction sent to the core.
- core_data  out  128  core input.
- core_done  in  1  core result valid.
- core_result  in  128  core output.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts the result.
- out_data  out  128  result.
- out_ch  out  CH_W  channel of the result.
- busy  out  1  the FSM is not in IDLE.

Function
REQ-005 The FSM SHALL have four states: IDLE, START, WAIT, OUT.
- IDLE -> START on in_valid & in_ready.
- START -> WAIT unconditionally.
- WAIT -> OUT on core_done.
- OUT -> IDLE on out_ready.
REQ-006 in_ready SHALL be high only in IDLE, and the accepted in_data, in_ch, in_encrypt and in_mode SHALL be captured on acceptance.
REQ-007 core_start SHALL be high exactly in START; core_data and core_encrypt SHALL be stable from START until leaving WAIT.
REQ-008 core_done SHALL be sampled only in WAIT and ignored in every other state.
REQ-009 Minimum latency SHALL be: accept at edge T, core_start during T+1, core_done earliest during T+2, out_valid from T+3.
REQ-010 out_valid SHALL be high only in OUT; out_data and out_ch SHALL be held until out_ready.
REQ-011 ECB SHALL use core_data = in_data and out = core_result; chain is unchanged.
REQ-012 CBC encrypt SHALL use core_data = in_data ^ chain[ch] and out = core_result, then set chain[ch] = core_result.
REQ-013 CBC decrypt SHALL use core_data = in_data and out = core_result ^ chain[ch], then set chain[ch] = in_data.
REQ-014 CTR SHALL use core_data = chain[ch] and force core_encrypt = 1 regardless of in_encrypt; out = in_data ^ core_result.
- The counter increment SHALL act on bits [31:0] only, wrap modulo 2^32, and leave bits [127:32] unchanged.
REQ-015 Mode 11 SHALL behave as ECB.
REQ-016 Chain update SHALL occur on the WAIT -> OUT edge.
REQ-017 iv_load SHALL write chain[iv_ch] = iv_data on the next edge, except when busy = 1 and iv_ch equals the captured channel.
- In that case the load SHALL be ignored and iv_drop SHALL pulse for one cycle.
REQ-018 An iv_load to a different channel while busy SHALL be accepted.

Reset
REQ-019 While rst is high, the state SHALL be IDLE and every chain register SHALL be 0.
REQ-020 While rst is high, in_ready, core_start, out_valid, iv_drop and busy SHALL be 0, and core_data, core_encrypt, out_data and out_ch SHALL be 0.
REQ-021 Reset mid-operation SHALL abandon the block without a chain update, and any later core_done SHALL be ignored.
REQ-022 in_ready SHALL rise on the first edge after rst falls.

Configuration
REQ-023 With AES_MODE_CTR_EN defined, CTR SHALL be supported as in REQ-014.
REQ-024 Without AES_MODE_CTR_EN, mode 10 SHALL behave as ECB and no counter incrementer SHALL be synthesised.

Structure
REQ-025 Package aes_pkg SHALL hold the AES_BLK_W = 128 constant, the aes_mode_t enum (ECB, CBC, CTR, RSVD) and the aes_ctrl_state_t enum.
REQ-026 The per-channel chain registers, IV load and drop logic SHALL be in the sub-module aes_chain_bank, parameterised by NUM_CH.

Verification
REQ-027 Bench core stub: core_result = ~core_data with core_done 3 cycles after core_start.
REQ-028 ECB, in_data = 0, out_ready = 1 -> out_data = all-ones; out_valid rises 5 edges after acceptance.
REQ-029 CBC encrypt, ch 2, IV = 1, blocks 0 then 0 -> outputs FFFF...FFFE, then 0000...0001.
REQ-030 CTR, IV = 128'h...00_FFFFFFFF, in_data = 0 -> out = ~IV; a second block sees a counter whose low 32 bits are 0 and whose upper 96 bits are unchanged.
REQ-031 out_ready held 0 for 10 cycles -> out_data stable, in_ready = 0, no second core_start.
REQ-032 rst asserted in WAIT, then core_done -> out_valid stays 0, chain registers 0, in_ready = 1 after reset.
REQ-033 iv_load to the active channel while busy -> iv_drop pulses once and chain is unchanged; the same load to another channel is applied.
